// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer: turns MemRead/MemWrite into a req/ack
// transaction on a word-wide memory and stalls the pipeline until it ends.
module mem_access_unit #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              flush,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              stall,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              misalign,
   output logic              timeout_err,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r;
   logic              access_s, reject_s, start_s, last_s, finish_s;
   logic              we_r, rdata_valid_r, misalign_r, timeout_err_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r, rdata_r;

   // Access classification, next-state decode and the combinational stall
   always_comb begin
      access_s = (mem_read | mem_write) & ~flush;
      reject_s = access_s & ((addr[1:0] != 2'b00) | (mem_read & mem_write));
      start_s  = access_s & ~reject_s;
      last_s   = (cnt_r == CNT_W'(TIMEOUT - 1));
      finish_s = 1'b0;
      state_s  = state_r;
      stall    = 1'b0;
      case (state_r)
         IDLE: begin
            // Gating with rst keeps stall low while reset is held
            if (start_s && !rst) begin
               stall   = 1'b1;
               state_s = REQ;
            end else begin
               stall   = 1'b0;
               state_s = IDLE;
            end
         end
         REQ: begin
            stall = 1'b1;
            if (m_ack || last_s) begin
               finish_s = 1'b1;
               state_s  = DONE;
            end else begin
               finish_s = 1'b0;
               state_s  = REQ;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register and the per-request cycle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         if (state_r == REQ) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= '0;
         end
      end
   end

   // Request latches, held until the instruction leaves DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= '0;
      end else if (state_r == IDLE && start_s) begin
         we_r    <= mem_write;
         addr_r  <= {addr[ADDR_W-1:2], 2'b00};
         wdata_r <= wdata;
      end
   end

   // Result capture and single-cycle status pulses aligned with DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_r       <= '0;
         rdata_valid_r <= 1'b0;
         misalign_r    <= 1'b0;
         timeout_err_r <= 1'b0;
      end else begin
         if (finish_s && !we_r) begin
            // A timed-out read returns zero rather than stale data
            rdata_r <= m_ack ? m_rdata : '0;
         end
         rdata_valid_r <= finish_s & ~we_r;
         timeout_err_r <= finish_s & ~m_ack;
         misalign_r    <= (state_r == IDLE) & reject_s;
      end
   end

   assign m_req       = (state_r == REQ);
   assign m_we        = we_r;
   assign m_addr      = addr_r;
   assign m_wdata     = wdata_r;
   assign rdata       = rdata_r;
   assign rdata_valid = rdata_valid_r;
   assign misalign    = misalign_r;
   assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; inputs change 1 time unit after the
// rising edge and outputs are sampled on the falling edge.
module tb_mem_access_unit;

   logic        clk, rst, mem_read, mem_write, flush, m_ack;
   logic [31:0] addr, wdata, m_rdata;
   logic        stall, rdata_valid, misalign, timeout_err, m_req, m_we;
   logic [31:0] rdata, m_addr, m_wdata;
   int          total, bad;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .flush(flush), .addr(addr), .wdata(wdata), .stall(stall),
      .rdata(rdata), .rdata_valid(rdata_valid), .misalign(misalign),
      .timeout_err(timeout_err), .m_req(m_req), .m_we(m_we),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0; m_ack = 1'b0;
      addr = 32'h0; wdata = 32'h0; m_rdata = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      total += 4;
      if (stall !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL reset_ctl: stall=%b m_req=%b want 0 0", stall, m_req); end
      if (rdata_valid !== 1'b0 || misalign !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL reset_pulse: rv=%b mis=%b to=%b want 0", rdata_valid, misalign, timeout_err); end
      if (rdata !== 32'h0 || m_addr !== 32'h0) begin bad++; $display("FAIL reset_data: rdata=%h m_addr=%h want 0", rdata, m_addr); end
      if (m_we !== 1'b0 || m_wdata !== 32'h0) begin bad++; $display("FAIL reset_wr: m_we=%b m_wdata=%h want 0", m_we, m_wdata); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_load();
      mem_read = 1'b1; addr = 32'h0000_0010;
      @(negedge clk);
      total += 2;
      if (stall !== 1'b1) begin bad++; $display("FAIL load_c1_stall: got %b want 1", stall); end
      if (m_req !== 1'b0) begin bad++; $display("FAIL load_c1_req: got %b want 0", m_req); end
      step();
      m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      total += 3;
      if (stall !== 1'b1 || m_req !== 1'b1) begin bad++; $display("FAIL load_c2_ctl: stall=%b m_req=%b want 1 1", stall, m_req); end
      if (m_addr !== 32'h10) begin bad++; $display("FAIL load_c2_addr: got %h want 00000010", m_addr); end
      if (m_we !== 1'b0) begin bad++; $display("FAIL load_c2_we: got %b want 0", m_we); end
      step();
      m_ack = 1'b0; m_rdata = 32'h0;
      @(negedge clk);
      total += 4;
      if (stall !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL load_c3_ctl: stall=%b m_req=%b want 0 0", stall, m_req); end
      if (rdata_valid !== 1'b1) begin bad++; $display("FAIL load_c3_valid: got %b want 1", rdata_valid); end
      if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_c3_rdata: got %h want deadbeef", rdata); end
      if (timeout_err !== 1'b0) begin bad++; $display("FAIL load_c3_to: got %b want 0", timeout_err); end
      clear_inputs();
      step();
      @(negedge clk);
      total += 1;
      if (rdata_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL load_c4_idle: rv=%b stall=%b want 0 0", rdata_valid, stall); end
      step();
   endtask

   task automatic test_store_wait();
      mem_write = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
      @(negedge clk);
      total += 1;
      if (stall !== 1'b1) begin bad++; $display("FAIL store_c1_stall: got %b want 1", stall); end
      step();
      addr = 32'h40; wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         m_ack = (i == 2);
         @(negedge clk);
         total += 3;
         if (stall !== 1'b1 || m_req !== 1'b1 || m_we !== 1'b1) begin bad++; $display("FAIL store_req%0d_ctl: stall=%b m_req=%b m_we=%b want 1 1 1", i, stall, m_req, m_we); end
         if (m_addr !== 32'h20 || m_wdata !== 32'h1234_5678) begin bad++; $display("FAIL store_req%0d_data: addr=%h wdata=%h want 00000020 12345678", i, m_addr, m_wdata); end
         if (rdata_valid !== 1'b0) begin bad++; $display("FAIL store_req%0d_rv: got %b want 0", i, rdata_valid); end
         step();
      end
      m_ack = 1'b0;
      @(negedge clk);
      total += 2;
      if (stall !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL store_done_ctl: stall=%b m_req=%b want 0 0", stall, m_req); end
      if (rdata_valid !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL store_done_pulse: rv=%b to=%b want 0 0", rdata_valid, timeout_err); end
      clear_inputs();
      step();
   endtask

   task automatic test_misalign();
      for (int k = 0; k < 2; k++) begin
         mem_read = 1'b1;
         mem_write = (k == 1);
         addr = (k == 0) ? 32'h13 : 32'h10;
         @(negedge clk);
         total += 1;
         if (stall !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL mis%0d_c1: stall=%b m_req=%b want 0 0", k, stall, m_req); end
         step();
         clear_inputs();
         @(negedge clk);
         total += 2;
         if (misalign !== 1'b1) begin bad++; $display("FAIL mis%0d_pulse: got %b want 1", k, misalign); end
         if (stall !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL mis%0d_c2: stall=%b m_req=%b want 0 0", k, stall, m_req); end
         step();
         @(negedge clk);
         total += 1;
         if (misalign !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL mis%0d_c3: mis=%b m_req=%b want 0 0", k, misalign, m_req); end
         step();
      end
   endtask

   task automatic test_timeout();
      mem_read = 1'b1; addr = 32'h50;
      @(negedge clk);
      step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total += 1;
         if (m_req !== 1'b1 || stall !== 1'b1 || timeout_err !== 1'b0) begin bad++; $display("FAIL to_req%0d: m_req=%b stall=%b to=%b want 1 1 0", i, m_req, stall, timeout_err); end
         step();
      end
      @(negedge clk);
      total += 3;
      if (timeout_err !== 1'b1 || rdata_valid !== 1'b1) begin bad++; $display("FAIL to_done_pulse: to=%b rv=%b want 1 1", timeout_err, rdata_valid); end
      if (rdata !== 32'h0) begin bad++; $display("FAIL to_done_rdata: got %h want 00000000", rdata); end
      if (stall !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL to_done_ctl: stall=%b m_req=%b want 0 0", stall, m_req); end
      clear_inputs();
      step();
      @(negedge clk);
      total += 1;
      if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_after: got %b want 0", timeout_err); end
      mem_read = 1'b1; addr = 32'h54;
      step();
      for (int i = 0; i < 4; i++) begin
         m_ack = (i == 3); m_rdata = 32'hCAFE_F00D;
         @(negedge clk);
         total += 1;
         if (m_req !== 1'b1) begin bad++; $display("FAIL ack4_req%0d: got %b want 1", i, m_req); end
         step();
      end
      m_ack = 1'b0;
      @(negedge clk);
      total += 2;
      if (timeout_err !== 1'b0 || rdata_valid !== 1'b1) begin bad++; $display("FAIL ack4_done_pulse: to=%b rv=%b want 0 1", timeout_err, rdata_valid); end
      if (rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL ack4_done_rdata: got %h want cafef00d", rdata); end
      clear_inputs();
      step();
   endtask

   task automatic test_flush();
      mem_write = 1'b1; flush = 1'b1; addr = 32'h60; m_ack = 1'b1;
      @(negedge clk);
      total += 1;
      if (stall !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL flush_c1: stall=%b m_req=%b want 0 0", stall, m_req); end
      step();
      clear_inputs();
      @(negedge clk);
      total += 1;
      if (m_req !== 1'b0 || misalign !== 1'b0 || rdata_valid !== 1'b0) begin bad++; $display("FAIL flush_c2: m_req=%b mis=%b rv=%b want 0 0 0", m_req, misalign, rdata_valid); end
      step();
   endtask

   task automatic test_reset_mid_req();
      mem_read = 1'b1; addr = 32'h70;
      step();
      @(negedge clk);
      total += 1;
      if (m_req !== 1'b1) begin bad++; $display("FAIL rstmid_pre: m_req=%b want 1", m_req); end
      #1 rst = 1'b1;
      #1;
      total += 3;
      if (m_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rstmid_ctl: m_req=%b stall=%b want 0 0", m_req, stall); end
      if (rdata_valid !== 1'b0 || misalign !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL rstmid_pulse: rv=%b mis=%b to=%b want 0", rdata_valid, misalign, timeout_err); end
      if (m_addr !== 32'h0 || m_we !== 1'b0 || m_wdata !== 32'h0 || rdata !== 32'h0) begin bad++; $display("FAIL rstmid_data: m_addr=%h m_we=%b m_wdata=%h rdata=%h want 0", m_addr, m_we, m_wdata, rdata); end
      clear_inputs();
      step();
      rst = 1'b0;
      @(negedge clk);
      total += 1;
      if (rdata_valid !== 1'b0 || m_req !== 1'b0) begin bad++; $display("FAIL rstmid_nocompl: rv=%b m_req=%b want 0 0", rdata_valid, m_req); end
      step();
      mem_read = 1'b1; addr = 32'h74;
      @(negedge clk);
      total += 1;
      if (stall !== 1'b1) begin bad++; $display("FAIL rstmid_ld_stall: got %b want 1", stall); end
      step();
      m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      total += 1;
      if (m_req !== 1'b1 || m_addr !== 32'h74) begin bad++; $display("FAIL rstmid_ld_req: m_req=%b m_addr=%h want 1 00000074", m_req, m_addr); end
      step();
      m_ack = 1'b0;
      @(negedge clk);
      total += 1;
      if (rdata_valid !== 1'b1 || rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL rstmid_ld_done: rv=%b rdata=%h want 1 0badf00d", rdata_valid, rdata); end
      clear_inputs();
      step();
   endtask

   task automatic test_back_to_back();
      mem_read = 1'b1; addr = 32'h80;
      @(negedge clk);
      step();
      m_ack = 1'b1; m_rdata = 32'h1111_2222;
      @(negedge clk);
      total += 1;
      if (m_req !== 1'b1) begin bad++; $display("FAIL b2b_lw_req: got %b want 1", m_req); end
      step();
      m_ack = 1'b0;
      @(negedge clk);
      total += 1;
      if (m_req !== 1'b0 || rdata_valid !== 1'b1) begin bad++; $display("FAIL b2b_lw_done: m_req=%b rv=%b want 0 1", m_req, rdata_valid); end
      mem_read = 1'b0; mem_write = 1'b1; addr = 32'h84; wdata = 32'h55AA_55AA;
      step();
      @(negedge clk);
      total += 1;
      if (m_req !== 1'b0 || stall !== 1'b1 || misalign !== 1'b0) begin bad++; $display("FAIL b2b_sw_idle: m_req=%b stall=%b mis=%b want 0 1 0", m_req, stall, misalign); end
      step();
      m_ack = 1'b1;
      @(negedge clk);
      total += 2;
      if (m_req !== 1'b1 || m_we !== 1'b1) begin bad++; $display("FAIL b2b_sw_req: m_req=%b m_we=%b want 1 1", m_req, m_we); end
      if (m_addr !== 32'h84 || m_wdata !== 32'h55AA_55AA) begin bad++; $display("FAIL b2b_sw_data: addr=%h wdata=%h want 00000084 55aa55aa", m_addr, m_wdata); end
      step();
      m_ack = 1'b0;
      @(negedge clk);
      total += 2;
      if (m_req !== 1'b0 || stall !== 1'b0 || rdata_valid !== 1'b0) begin bad++; $display("FAIL b2b_sw_done: m_req=%b stall=%b rv=%b want 0 0 0", m_req, stall, rdata_valid); end
      if (misalign !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL b2b_spurious: mis=%b to=%b want 0 0", misalign, timeout_err); end
      clear_inputs();
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_load();
      test_store_wait();
      test_misalign();
      test_timeout();
      test_flush();
      test_reset_mid_req();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
